// File: rtl/plot_arbiter_if.sv
// Pixel producer bus: three requesters, each with a valid/ready pair and a pixel payload.
interface plot_arbiter_if;
   logic [2:0] req;
   logic [2:0] gnt;
   logic [7:0] x0, x1, x2;
   logic [7:0] y0, y1, y2;
   logic [2:0] c0, c1, c2;

   modport master (output req, x0, x1, x2, y0, y1, y2, c0, c1, c2, input gnt);
   modport slave  (input req, x0, x1, x2, y0, y1, y2, c0, c1, c2, output gnt);
endinterface

// File: rtl/plot_arbiter.sv
// Round-robin, burst-locked arbiter sharing the VGA adapter pixel port among three producers;
// registers the winning pixel onto the adapter and drops off-screen pixels.
module plot_arbiter #(
   parameter int unsigned X_MAX     = 159,
   parameter int unsigned Y_MAX     = 119,
   parameter int unsigned MAX_BURST = 16
) (
   input  logic          clk,
   input  logic          reset,
   plot_arbiter_if.slave bus,
   output logic [7:0]    x,
   output logic [7:0]    y,
   output logic [2:0]    colour,
   output logic          plot,
   output logic [1:0]    owner,
   output logic [7:0]    drop_count
);

   localparam int unsigned CNT_W = 8;
   localparam logic [1:0]       NONE      = 2'd3;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
   localparam logic [7:0]       X_LIM     = 8'(X_MAX);
   localparam logic [7:0]       Y_LIM     = 8'(Y_MAX);

   typedef enum logic {IDLE, OWN} state_t;

   state_t           state_q, state_n;
   logic [1:0]       owner_q, owner_n;
   logic [1:0]       rr_q, rr_n;
   logic [CNT_W-1:0] bcnt_q, bcnt_n;
   logic             own_req;
   logic             xfer;
   logic [2:0]       arb;
   logic [7:0]       px, py;
   logic [2:0]       pc;
   logic             on_screen;

   function automatic logic [1:0] inc3(input logic [1:0] v);
      return (v == 2'd2) ? 2'd0 : v + 2'd1;
   endfunction

   function automatic logic req_bit(input logic [2:0] r, input logic [1:0] i);
      case (i)
         2'd0:    return r[0];
         2'd1:    return r[1];
         2'd2:    return r[2];
         default: return 1'b0;
      endcase
   endfunction

   // Returns {found, index} of the first set request scanning start, start+1, start+2 (mod 3).
   function automatic logic [2:0] pick(input logic [1:0] start, input logic [2:0] r);
      logic [2:0] res;
      logic [1:0] idx;
      res = 3'b000;
      idx = start;
      for (int i = 0; i < 3; i++) begin
         if (!res[2] && req_bit(r, idx)) res = {1'b1, idx};
         idx = inc3(idx);
      end
      return res;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         owner_q <= NONE;
         rr_q    <= 2'd0;
         bcnt_q  <= '0;
      end else begin
         state_q <= state_n;
         owner_q <= owner_n;
         rr_q    <= rr_n;
         bcnt_q  <= bcnt_n;
      end
   end

   // Next ownership; a burst end re-arbitrates on the same edge so a waiting producer loses no cycle.
   always_comb begin
      state_n = state_q;
      owner_n = owner_q;
      rr_n    = rr_q;
      bcnt_n  = bcnt_q;
      xfer    = 1'b0;
      arb     = 3'b000;
      own_req = req_bit(bus.req, owner_q);
      case (state_q)
         IDLE: begin
            arb = pick(rr_q, bus.req);
            if (arb[2]) begin
               state_n = OWN;
               owner_n = arb[1:0];
               bcnt_n  = '0;
            end
         end
         OWN: begin
            xfer = own_req;
            if (!own_req || bcnt_q == LAST_BEAT) begin
               rr_n   = inc3(owner_q);
               arb    = pick(inc3(owner_q), bus.req);
               bcnt_n = '0;
               if (arb[2]) begin
                  owner_n = arb[1:0];
               end else begin
                  state_n = IDLE;
                  owner_n = NONE;
               end
            end else begin
               bcnt_n = bcnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_n = IDLE;
            owner_n = NONE;
         end
      endcase
   end

   assign bus.gnt = (state_q == OWN && own_req) ? (3'b001 << owner_q) : 3'b000;
   assign owner   = owner_q;

   always_comb begin
      px = bus.x0;
      py = bus.y0;
      pc = bus.c0;
      case (owner_q)
         2'd1: begin px = bus.x1; py = bus.y1; pc = bus.c1; end
         2'd2: begin px = bus.x2; py = bus.y2; pc = bus.c2; end
         default: ;
      endcase
      on_screen = (px <= X_LIM) && (py <= Y_LIM);
   end

   // Adapter port: off-screen pixels are still accepted but only counted, never plotted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         plot       <= 1'b0;
         x          <= '0;
         y          <= '0;
         colour     <= '0;
         drop_count <= '0;
      end else begin
         plot <= xfer && on_screen;
         if (xfer) begin
            x      <= px;
            y      <= py;
            colour <= pc;
         end
         if (xfer && !on_screen && drop_count != 8'hFF)
            drop_count <= drop_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_plot_arbiter.sv
// Randomized and directed bench for plot_arbiter against a transaction-level ownership model.
module tb_plot_arbiter;

   localparam int MAX_BURST = 16;
   localparam int X_MAX     = 159;
   localparam int Y_MAX     = 119;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] x, y, drop_count;
   logic [2:0] colour;
   logic       plot;
   logic [1:0] owner;

   plot_arbiter_if bus ();

   plot_arbiter #(.X_MAX(X_MAX), .Y_MAX(Y_MAX), .MAX_BURST(MAX_BURST)) dut (
      .clk(clk), .reset(reset), .bus(bus), .x(x), .y(y), .colour(colour),
      .plot(plot), .owner(owner), .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
      end
   endtask

   // stimulus arrays
   logic [2:0] sreq;
   logic [7:0] sx [3];
   logic [7:0] sy [3];
   logic [2:0] sc [3];

   task automatic drive();
      bus.req = sreq;
      bus.x0 = sx[0]; bus.y0 = sy[0]; bus.c0 = sc[0];
      bus.x1 = sx[1]; bus.y1 = sy[1]; bus.c1 = sc[1];
      bus.x2 = sx[2]; bus.y2 = sy[2]; bus.c2 = sc[2];
   endtask

   // reference model: who owns, how many pixels in this burst, where the search starts next
   int         m_owner, m_rr, m_cnt, e_drop;
   logic       e_plot;
   logic [7:0] e_x, e_y;
   logic [2:0] e_c;
   logic [2:0] last_xfer;

   function automatic logic has_req(input logic [2:0] r, input int n);
      return ((r >> n) & 3'b001) != 3'b000;
   endfunction

   function automatic logic [2:0] exp_gnt();
      if (m_owner >= 0 && has_req(bus.req, m_owner)) return 3'(1 << m_owner);
      return 3'b000;
   endfunction

   task automatic model_reset();
      m_owner = -1; m_rr = 0; m_cnt = 0; e_drop = 0;
      e_plot = 1'b0; e_x = 8'd0; e_y = 8'd0; e_c = 3'd0;
      last_xfer = 3'b000;
   endtask

   task automatic model_edge();
      logic [2:0] r;
      logic       done;
      int         n;
      r = bus.req;
      e_plot = 1'b0;
      last_xfer = exp_gnt();
      if (m_owner >= 0) begin
         done = 1'b0;
         if (has_req(r, m_owner)) begin
            e_x = sx[m_owner]; e_y = sy[m_owner]; e_c = sc[m_owner];
            if (int'(e_x) <= X_MAX && int'(e_y) <= Y_MAX) e_plot = 1'b1;
            else if (e_drop < 255) e_drop++;
            m_cnt++;
            if (m_cnt == MAX_BURST) done = 1'b1;
         end else begin
            done = 1'b1;
         end
         if (done) begin
            m_rr = (m_owner + 1) % 3;
            m_owner = -1;
         end
      end
      if (m_owner < 0) begin
         for (int k = 0; k < 3; k++) begin
            n = (m_rr + k) % 3;
            if (m_owner < 0 && has_req(r, n)) begin
               m_owner = n;
               m_cnt = 0;
            end
         end
      end
   endtask

   task automatic check_all();
      check("gnt", 32'(bus.gnt), 32'(exp_gnt()));
      check("owner", 32'(owner), (m_owner < 0) ? 32'd3 : 32'(m_owner));
      check("plot", 32'(plot), 32'(e_plot));
      check("x", 32'(x), 32'(e_x));
      check("y", 32'(y), 32'(e_y));
      check("colour", 32'(colour), 32'(e_c));
      check("drop_count", 32'(drop_count), 32'(e_drop));
   endtask

   // one clock: check at the falling edge, step the model on the rising edge, return at edge+1
   task automatic tick();
      @(negedge clk);
      check_all();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic do_reset();
      sreq = 3'b000;
      drive();
      reset = 1'b1;
      #4;
      model_reset();
      reset = 1'b0;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   int plots;

   initial begin
      for (int i = 0; i < 3; i++) begin sx[i] = 8'd0; sy[i] = 8'd0; sc[i] = 3'd0; end
      sreq = 3'b000;
      drive();
      model_reset();
      do_reset();
      check("rst_gnt", 32'(bus.gnt), 32'd0);
      check("rst_owner", 32'(owner), 32'd3);
      check("rst_plot", 32'(plot), 32'd0);
      check("rst_xyc", {8'd0, x, y, 5'd0, colour}, 32'd0);
      check("rst_drop", 32'(drop_count), 32'd0);

      // single requester, three pixels
      sreq = 3'b001; sx[0] = 8'd5; sy[0] = 8'd7; sc[0] = 3'b111;
      drive();
      tick();
      check("t1_gnt", 32'(bus.gnt), 32'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t1_plot", 32'(plot), 32'd1);
         check("t1_pix", {8'd0, x, y, 5'd0, colour}, {8'd0, 8'd5, 8'd7, 8'd7});
         check("t1_owner", 32'(owner), 32'd0);
      end
      sreq = 3'b000; drive();
      tick();
      check("t1_end_plot", 32'(plot), 32'd0);

      // all three requesting: 16-pixel bursts in order 0,1,2,0 with no gap
      do_reset();
      for (int i = 0; i < 3; i++) begin sx[i] = 8'(10 * i); sy[i] = 8'(i); sc[i] = 3'(i); end
      sreq = 3'b111; drive();
      tick();
      for (int i = 0; i < 64; i++) begin
         check("rr_gnt", 32'(bus.gnt), 32'(1 << ((i / 16) % 3)));
         tick();
      end

      // requester 1 gives up after 4 pixels while 2 waits
      do_reset();
      sx[1] = 8'd50; sx[2] = 8'd60; sy[1] = 8'd1; sy[2] = 8'd2;
      sreq = 3'b010; drive();
      tick();
      sreq = 3'b110; drive();
      plots = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (plot && x == 8'd50) plots++;
      end
      sreq = 3'b100; drive();
      for (int i = 0; i < 3; i++) begin
         tick();
         if (i == 0) check("drop_owner", 32'(owner), 32'd2);
         if (plot && x == 8'd50) plots++;
      end
      check("drop_r1_plots", 32'(plots), 32'd4);

      // lone requester keeps re-winning across burst boundaries
      do_reset();
      sx[0] = 8'd1; sy[0] = 8'd1;
      sreq = 3'b001; drive();
      tick();
      plots = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (plot) plots++;
      end
      sreq = 3'b000; drive();
      for (int i = 0; i < 3; i++) begin
         tick();
         if (plot) plots++;
      end
      check("solo_plots", 32'(plots), 32'd40);

      // off-screen pixels are acknowledged but not plotted
      do_reset();
      sreq = 3'b100; sx[2] = 8'd160; sy[2] = 8'd10; drive();
      tick();
      plots = 0;
      check("os_ack0", 32'(bus.gnt), 32'd4);
      tick();
      if (plot) plots++;
      sx[2] = 8'd20; sy[2] = 8'd120; drive();
      check("os_ack1", 32'(bus.gnt), 32'd4);
      tick();
      if (plot) plots++;
      sx[2] = 8'd20; sy[2] = 8'd20; drive();
      check("os_ack2", 32'(bus.gnt), 32'd4);
      tick();
      if (plot) plots++;
      check("os_onscreen_xy", {16'd0, x, y}, {16'd0, 8'd20, 8'd20});
      sreq = 3'b000; drive();
      tick();
      if (plot) plots++;
      check("os_plots", 32'(plots), 32'd1);
      check("os_drops", 32'(drop_count), 32'd2);

      // reset in the middle of a burst
      do_reset();
      sreq = 3'b010; sx[1] = 8'd30; sy[1] = 8'd30; drive();
      tick(); tick(); tick();
      reset = 1'b1;
      #2;
      check("mid_rst_gnt", 32'(bus.gnt), 32'd0);
      check("mid_rst_plot", 32'(plot), 32'd0);
      check("mid_rst_owner", 32'(owner), 32'd3);
      model_reset();
      sreq = 3'b110; drive();
      #2;
      reset = 1'b0;
      @(posedge clk);
      model_edge();
      #1;
      check("mid_rst_regrant", 32'(owner), 32'd1);
      check("mid_rst_gnt1", 32'(bus.gnt), 32'd2);
      tick();

      // random traffic, producers hold pixels while waiting
      for (int cyc = 0; cyc < 2000; cyc++) begin
         for (int n = 0; n < 3; n++) begin
            if (has_req(sreq, n) && !has_req(last_xfer, n)) begin
               if ($urandom_range(0, 7) == 0) sreq[n] = 1'b0;
            end else begin
               sreq[n] = ($urandom_range(0, 3) != 0);
               sx[n] = 8'($urandom_range(0, 175));
               sy[n] = 8'($urandom_range(0, 135));
               sc[n] = 3'($urandom_range(0, 7));
            end
         end
         drive();
         tick();
      end
      sreq = 3'b000; drive();
      tick(); tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/plot_arbiter.md
# plot_arbiter

Shares the VGA adapter's single pixel write port (x, y, colour, plot) between up to three pixel producers: wall renderer, sprite renderer and menu/score overlay. It sits between those producers and the vga_adapter instance. It grants ownership round-robin with burst locking, so one producer's column scan is not interleaved with another's. It registers the winning pixel onto the adapter port and drops off-screen pixels.

## Interface
- X_MAX, default 159: largest legal x coordinate (160x120 mode).
- Y_MAX, default 119: largest legal y coordinate.
- MAX_BURST, default 16: maximum transfers per ownership before forced re-arbitration (range 1..255).
- clk  in  1  system clock (CLOCK_50 domain).
- reset  in  1  asynchronous, active-high reset.
- req  in  3  per-requester pixel valid; bit n belongs to requester n.
- x0, x1, x2  in  8 each  requester pixel x.
- y0, y1, y2  in  8 each  requester pixel y.
- c0, c1, c2  in  3 each  requester pixel colour.
- gnt  out  3  per-requester ready; a pixel transfers on any rising edge where req[n] and gnt[n] are both 1.
- x  out  8  registered pixel x to the adapter.
- y  out  8  registered pixel y to the adapter.
- colour  out  3  registered pixel colour to the adapter.
- plot  out  1  registered write strobe to the adapter.
- owner  out  2  current owner index; 3 means none.
- drop_count  out  8  saturating count of off-screen pixels accepted.

## Operation
- States:
  - IDLE: no owner.
  - OWN: owner locked, burst counter bcnt of 8 bits.
- gnt logic:
  - gnt[n] = (state==OWN) && (owner==n) && req[n]; all other bits are 0.
  - gnt is combinational from registers and req only; x/y/c do not affect gnt.
- Round-robin pointer rr (2 bits, values 0..2) selects the search start for the next arbitration.
- IDLE, any req bit set:
  - Next state OWN.
  - owner = first set bit scanning rr, rr+1, rr+2 (mod 3).
  - bcnt = 0.
- IDLE, req = 0: stay in IDLE.
- OWN, transfer this cycle: bcnt increments.
- OWN, end of ownership:
  - Triggered by req[owner]==0, or by a transfer that makes bcnt reach MAX_BURST.
  - rr = owner+1 (mod 3).
  - The same edge re-arbitrates from the new rr over the current req bits. A winner gives state OWN with bcnt=0; no winner gives IDLE.
  - A requester whose burst just expired is re-selected only if no other requester is asserting.
- Output stage, each edge:
  - plot = transfer && on-screen, where on-screen means x ≤ X_MAX && y ≤ Y_MAX of the owner's pixel.
  - x, y, colour load the owner's pixel on every transfer, including dropped ones. Otherwise they hold.
- Off-screen pixels are still acknowledged via gnt so the producer advances. drop_count increments per such transfer and saturates at 255.
- owner output: the owner index in OWN, 3 in IDLE.

## Timing
- Reset (asynchronous, immediate): state IDLE, rr=0, bcnt=0, gnt=0, owner=3, plot=0, x=0, y=0, colour=0, drop_count=0.
- Arbitration latency is 1 cycle: req rising in IDLE gives gnt high in the next cycle.
- Pixel latency is 1 cycle: a transfer at edge k drives plot/x/y/colour during cycle k+1.
- plot is high for exactly one cycle per on-screen transfer.
- Sustained rate for a held owner is one pixel per clock.
- Switching owners at burst end costs zero dead cycles when another requester is waiting.
- Producers must hold x/y/c stable while req is high and gnt is low.
- A producer may drop req at any time. The next edge ends ownership with no transfer.
- Reset asserted mid-burst:
  - gnt and plot clear immediately and no partial pixel is emitted.
  - After release, arbitration restarts from rr=0.
- MAX_BURST=1 degenerates to per-pixel round-robin.

## Test plan
- Reset then req=3'b001, x0=5, y0=7, c0=3'b111 held for 3 cycles:
  - gnt[0] rises 1 cycle after req.
  - plot is high on the following 3 cycles with x=5, y=7, colour=7.
  - owner=0.
- req=3'b111 held, MAX_BURST=16:
  - Grants run 16 transfers to requester 0, then 16 to 1, then 16 to 2, then back to 0.
  - No idle cycle appears between bursts.
- Requester 1 owns, drops req after 4 transfers while req[2]=1:
  - Next edge gives owner=2 and rr=2.
  - Exactly 4 plot pulses were sourced from requester 1.
- Only requester 0 requesting for 40 cycles: owner re-selected after each 16-transfer burst, giving 40 continuous plot pulses.
- Requester 2 sends x=160, y=10, then x=20, y=120, then x=20, y=20:
  - All three are acknowledged via gnt.
  - plot pulses only for (20,20).
  - drop_count=2.
- Assert reset while requester 1 is mid-burst:
  - gnt=0, plot=0, owner=3 immediately, with no clock edge needed.
  - After release with req=3'b110, requester 1 is granted first.
